// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter: register-file write port arbiter between ALU writeback and a multi-cycle result FIFO
//
// Ports:
//   clk, reset                      clock and synchronous active-high reset
//   alu_we/alu_waddr/alu_wdata      ALU writeback request (highest priority)
//   alu_accept                      ALU request consumed this cycle (0 during a forced drain)
//   mc_valid/mc_waddr/mc_wdata      multi-cycle completion, enqueued when mc_ready
//   mc_ready                        FIFO not full
//   stall_req                       pipeline freeze while the FIFO head is force-drained
//   rf_we/rf_waddr/rf_wdata         registered register-file write port
//   chk_addr1/2, chk_hit1/2         pending-write hazard queries (combinational)
//   q_count                         FIFO occupancy
module rf_writeback_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int QDEPTH   = 4,
    parameter int MAX_WAIT = 8,
    localparam int CW      = $clog2(QDEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_we,
    input  logic [ADDR_W-1:0] alu_waddr,
    input  logic [DATA_W-1:0] alu_wdata,
    output logic              alu_accept,
    input  logic              mc_valid,
    output logic              mc_ready,
    input  logic [ADDR_W-1:0] mc_waddr,
    input  logic [DATA_W-1:0] mc_wdata,
    output logic              stall_req,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [ADDR_W-1:0] chk_addr1,
    input  logic [ADDR_W-1:0] chk_addr2,
    output logic              chk_hit1,
    output logic              chk_hit2,
    output logic [CW-1:0]     q_count
);
    localparam int PW = $clog2(QDEPTH);
    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic {NORMAL, DRAIN} state_t;

    state_t            state_q, state_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic [ADDR_W-1:0] addr_q [QDEPTH];
    logic [ADDR_W-1:0] addr_d [QDEPTH];
    logic [DATA_W-1:0] data_q [QDEPTH];
    logic [DATA_W-1:0] data_d [QDEPTH];
    logic              push, pop, issue_alu;
    logic [QDEPTH-1:0] ent_valid, hit1_vec, hit2_vec;

    assign mc_ready   = count_q != CW'(QDEPTH);
    assign stall_req  = state_q == DRAIN;
    assign alu_accept = state_q == NORMAL;
    assign q_count    = count_q;
    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;

    always_comb begin
        // Writes to r0 are swallowed at the source so they never occupy a slot.
        push      = mc_valid && mc_ready && (mc_waddr != '0);
        issue_alu = (state_q == NORMAL) && alu_we && (alu_waddr != '0);
        pop       = (count_q != '0) && (state_q == DRAIN || !alu_we);
        rf_we_d    = issue_alu || pop;
        rf_waddr_d = issue_alu ? alu_waddr : pop ? addr_q[rd_ptr_q] : rf_waddr_q;
        rf_wdata_d = issue_alu ? alu_wdata : pop ? data_q[rd_ptr_q] : rf_wdata_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        addr_d = addr_q;
        data_d = data_q;
        if (push) begin
            addr_d[wr_ptr_q] = mc_waddr;
            data_d[wr_ptr_q] = mc_wdata;
        end
        wait_d  = (count_q != '0 && !pop) ? wait_q + WW'(1) : '0;
        state_d = (state_q == NORMAL && wait_q == WW'(MAX_WAIT - 1) && !pop) ? DRAIN : NORMAL;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= NORMAL;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            wait_q     <= '0;
        end else begin
            state_q    <= state_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            wait_q     <= wait_d;
        end
        addr_q <= addr_d;
        data_q <= data_d;
    end

    // A slot is live when its distance from the read pointer is below the occupancy.
    for (genvar i = 0; i < QDEPTH; i++) begin : g_hit
        assign ent_valid[i] = {1'b0, PW'(i) - rd_ptr_q} < count_q;
        assign hit1_vec[i]  = ent_valid[i] && addr_q[i] == chk_addr1;
        assign hit2_vec[i]  = ent_valid[i] && addr_q[i] == chk_addr2;
    end

    assign chk_hit1 = (chk_addr1 != '0) && ((|hit1_vec) || (rf_we_q && rf_waddr_q == chk_addr1));
    assign chk_hit2 = (chk_addr2 != '0) && ((|hit2_vec) || (rf_we_q && rf_waddr_q == chk_addr2));
endmodule
